// File: rtl/debug_pipeline_controller.sv
// Debug sequencer for the MIPS pipeline: gates the stage enable for run/step/halt and streams
// a register-bank snapshot out as bytes over a ready/valid link toward the UART TX path.
module debug_pipeline_controller #(
    parameter int unsigned REGISTERS_BANK_SIZE = 32,
    parameter int unsigned BUS_SIZE            = 32,
    parameter int unsigned CYCLE_COUNTER_SIZE  = 32
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_cmd_valid,
    input  logic [7:0]                                i_cmd,
    output logic                                      o_cmd_ready,
    input  logic                                      i_halt_detected,
    input  logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0]   i_registers_bank,
    output logic                                      o_pipeline_enable,
    output logic [7:0]                                o_tx_data,
    output logic                                      o_tx_valid,
    input  logic                                      i_tx_ready,
    output logic [CYCLE_COUNTER_SIZE-1:0]             o_cycle_count,
    output logic                                      o_busy
);

    localparam int unsigned BankW       = REGISTERS_BANK_SIZE * BUS_SIZE;
    localparam int unsigned BytesPerReg = BUS_SIZE / 8;
    localparam int unsigned NumBytes    = BankW / 8;
    localparam int unsigned IdxW        = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

    localparam logic [7:0] CmdRun  = 8'h43;
    localparam logic [7:0] CmdStep = 8'h53;
    localparam logic [7:0] CmdDump = 8'h44;
    localparam logic [7:0] CmdHalt = 8'h48;
    localparam logic [7:0] ErrByte = 8'hEE;

    typedef enum logic [2:0] {StIdle, StRun, StStep, StSnap, StSend, StErr} state_e;

    state_e                          state_q, state_d;
    logic                            enable_q, enable_d;
    logic                            tx_valid_q, tx_valid_d;
    logic [7:0]                      tx_data_q, tx_data_d;
    logic [CYCLE_COUNTER_SIZE-1:0]   count_q, count_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic [BankW-1:0]                snap_q, snap_d;
    logic                            cmd_fire, tx_fire;

    // Byte k: register k/BytesPerReg, most significant byte of each register first.
    function automatic logic [7:0] pick_byte(input logic [BankW-1:0] bank,
                                             input logic [IdxW-1:0] k);
        int unsigned r, b, off;
        logic [BankW-1:0] shifted;
        r       = 32'(k) / BytesPerReg;
        b       = 32'(k) % BytesPerReg;
        off     = r * BUS_SIZE + BUS_SIZE - 8 - 8 * b;
        shifted = bank >> off;
        return shifted[7:0];
    endfunction

    assign o_cmd_ready = (state_q == StIdle) || (state_q == StRun);
    assign o_busy      = (state_q != StIdle);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;
    assign tx_fire     = tx_valid_q && i_tx_ready;

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    case (i_cmd)
                        CmdRun:  state_d = StRun;
                        CmdStep: state_d = StStep;
                        CmdDump: state_d = StSnap;
                        CmdHalt: state_d = StIdle;
                        default: begin
                            state_d    = StErr;
                            tx_valid_d = 1'b1;
                            tx_data_d  = ErrByte;
                        end
                    endcase
                end
            end
            StRun: begin
                // A halt from the pipeline outranks a host halt: the dump must still happen.
                if (i_halt_detected) begin
                    state_d = StSnap;
                end else if (cmd_fire && (i_cmd == CmdHalt)) begin
                    state_d = StIdle;
                end
            end
            StStep: state_d = StSnap;
            StSnap: begin
                snap_d     = i_registers_bank;
                idx_d      = '0;
                tx_valid_d = 1'b1;
                tx_data_d  = pick_byte(i_registers_bank, '0);
                state_d    = StSend;
            end
            StSend: begin
                if (tx_fire) begin
                    if (idx_q == LastIdx) begin
                        tx_valid_d = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        idx_d     = idx_q + IdxW'(1);
                        tx_data_d = pick_byte(snap_q, idx_q + IdxW'(1));
                    end
                end
            end
            StErr: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        enable_d = (state_d == StRun) || (state_d == StStep);
        count_d  = (enable_q && (count_q != '1)) ? count_q + CYCLE_COUNTER_SIZE'(1) : count_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            enable_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            count_q    <= '0;
            idx_q      <= '0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
        end
    end

    assign o_pipeline_enable = enable_q;
    assign o_tx_valid        = tx_valid_q;
    assign o_tx_data         = tx_data_q;
    assign o_cycle_count     = count_q;

endmodule

// File: tb/tb_debug_pipeline_controller.sv
// Scoreboard bench: stimulus queues expected TX bytes, a negedge monitor pops and compares them.
module tb_debug_pipeline_controller;

    localparam int NR     = 32;
    localparam int BW     = 32;
    localparam int CW     = 32;
    localparam int NBYTES = NR * BW / 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic [7:0]         cmd;
    logic               cmd_ready;
    logic               halt;
    logic [NR*BW-1:0]   bank;
    logic               en;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [CW-1:0]      cycle_count;
    logic               busy;

    always #5 clk = ~clk;

    debug_pipeline_controller #(
        .REGISTERS_BANK_SIZE(NR),
        .BUS_SIZE(BW),
        .CYCLE_COUNTER_SIZE(CW)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_cmd_valid(cmd_valid),
        .i_cmd(cmd),
        .o_cmd_ready(cmd_ready),
        .i_halt_detected(halt),
        .i_registers_bank(bank),
        .o_pipeline_enable(en),
        .o_tx_data(tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .o_cycle_count(cycle_count),
        .o_busy(busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    int          en_seen = 0;
    int          base_hs;
    int          base_en;
    int          n;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_log[$];
    logic [7:0]  exp_byte;
    logic        stall_pending = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen here completes on the following rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_pending = 1'b0;
            end else begin
                if (en) en_seen++;
                if (stall_pending) begin
                    check("stall_valid", 64'(tx_valid), 64'(1));
                    check("stall_data", 64'(tx_data), 64'(stall_data));
                end
                if (tx_valid && tx_ready) begin
                    hs_count++;
                    rx_log.push_back(tx_data);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_data);
                    end else begin
                        exp_byte = exp_q.pop_front();
                        check("tx_byte", 64'(tx_data), 64'(exp_byte));
                    end
                end
                stall_pending = tx_valid && !tx_ready;
                stall_data    = tx_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        halt      = 1'b0;
        tx_ready  = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        exp_q.delete();
        rx_log.delete();
    endtask

    task automatic send_cmd(input logic [7:0] c);
        int k = 0;
        while (!cmd_ready && k < 100) begin
            tick();
            k++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
        cmd       = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 2000) begin
            tick();
            k++;
        end
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'(0));
    endtask

    // Expected stream: register 0 first, top byte of each register first.
    task automatic push_dump(input logic [NR*BW-1:0] b);
        for (int r = 0; r < NR; r++) begin
            for (int j = BW / 8 - 1; j >= 0; j--) begin
                exp_q.push_back(b[r*BW + 8*j +: 8]);
            end
        end
    endtask

    function automatic logic [NR*BW-1:0] make_bank(input logic [7:0] seed);
        logic [NR*BW-1:0] b;
        for (int i = 0; i < NR; i++) begin
            b[i*BW +: BW] = {8'(i), seed, 8'(i * 3 + 1), ~8'(i)};
        end
        return b;
    endfunction

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 8'h00;
        halt      = 1'b0;
        tx_ready  = 1'b1;
        bank      = make_bank(8'h5A);
        repeat (3) tick();
        reset = 1'b0;
        check("rst_enable", 64'(en), 64'(0));
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_cycle_count", 64'(cycle_count), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));

        // Single step with reg1 = 0x11223344.
        bank = make_bank(8'h21);
        bank[1*BW +: BW] = 32'h1122_3344;
        rx_log.delete();
        base_en = en_seen;
        base_hs = hs_count;
        push_dump(bank);
        send_cmd(8'h53);
        wait_idle("step");
        check("step_enable_cycles", 64'(en_seen - base_en), 64'(1));
        check("step_cycle_count", 64'(cycle_count), 64'(1));
        check("step_handshakes", 64'(hs_count - base_hs), 64'(NBYTES));
        check("step_byte4", 64'(rx_log[4]), 64'(8'h11));
        check("step_byte5", 64'(rx_log[5]), 64'(8'h22));
        check("step_byte6", 64'(rx_log[6]), 64'(8'h33));
        check("step_byte7", 64'(rx_log[7]), 64'(8'h44));

        // Run, halt detected on the 10th enabled cycle.
        do_reset();
        bank = make_bank(8'h33);
        base_hs = hs_count;
        push_dump(bank);
        send_cmd(8'h43);
        repeat (9) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("run_halt_enable_off", 64'(en), 64'(0));
        check("run_halt_cycle_count", 64'(cycle_count), 64'(10));
        wait_idle("run_halt");
        check("run_halt_handshakes", 64'(hs_count - base_hs), 64'(NBYTES));

        // Dump with back-pressure; bus changes after the snapshot.
        do_reset();
        bank = make_bank(8'hC4);
        base_hs = hs_count;
        push_dump(bank);
        send_cmd(8'h44);
        n = 0;
        while (busy && n < 2000) begin
            tx_ready = (n % 2 == 1);
            if (n == 10) bank = ~bank;
            tick();
            n++;
        end
        tx_ready = 1'b1;
        wait_idle("bp_dump");
        check("bp_handshakes", 64'(hs_count - base_hs), 64'(NBYTES));

        // Unknown command yields a single error byte.
        do_reset();
        base_hs = hs_count;
        exp_q.push_back(8'hEE);
        send_cmd(8'h58);
        wait_idle("err");
        check("err_handshakes", 64'(hs_count - base_hs), 64'(1));

        // Run, host halt after 5 enabled cycles: no dump.
        do_reset();
        base_hs = hs_count;
        send_cmd(8'h43);
        repeat (4) tick();
        send_cmd(8'h48);
        check("host_halt_enable_off", 64'(en), 64'(0));
        check("host_halt_cycle_count", 64'(cycle_count), 64'(5));
        check("host_halt_busy", 64'(busy), 64'(0));
        repeat (3) tick();
        check("host_halt_handshakes", 64'(hs_count - base_hs), 64'(0));

        // Reset after byte 50 completes, then a fresh dump restarts at byte 0.
        do_reset();
        bank = make_bank(8'h66);
        base_hs = hs_count;
        push_dump(bank);
        send_cmd(8'h44);
        n = 0;
        while ((hs_count - base_hs) < 51 && n < 2000) begin
            tick();
            n++;
        end
        check("abort_reached_byte50", 64'(hs_count - base_hs), 64'(51));
        reset = 1'b1;
        tick();
        check("abort_tx_valid", 64'(tx_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_queue_left", 64'(exp_q.size()), 64'(NBYTES - 51));
        exp_q.delete();
        reset = 1'b0;
        tick();
        rx_log.delete();
        base_hs = hs_count;
        push_dump(bank);
        send_cmd(8'h44);
        wait_idle("restart");
        check("restart_handshakes", 64'(hs_count - base_hs), 64'(NBYTES));
        check("restart_first_byte", 64'(rx_log[0]), 64'(8'h00));
        check("restart_second_byte", 64'(rx_log[1]), 64'(8'h66));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_pipeline_controller.md
Name: debug_pipeline_controller

Overview:
Sequences execution of the MIPS pipeline for the debug host and extracts the register-bank snapshot from the ID stage debug bus. It gates the pipeline through a single enable in three modes: continuous run, single step and halt. After a run or step completes, it serializes every register as a byte stream over a ready/valid interface toward the UART TX path. It sits between the UART command decoder and the pipeline stage enables.

Parameters:
REGISTERS_BANK_SIZE, 32, number of registers in the debug bus
BUS_SIZE, 32, width of each register; must be a multiple of 8
CYCLE_COUNTER_SIZE, 32, width of the enabled-cycle counter

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous reset, active-high
i_cmd_valid  in  1  command byte present
i_cmd  in  8  command byte: 0x43 'C' run, 0x53 'S' step, 0x44 'D' dump, 0x48 'H' halt
o_cmd_ready  out  1  command accepted when i_cmd_valid && o_cmd_ready
i_halt_detected  in  1  end-of-program instruction reached in the pipeline
i_registers_bank  in  REGISTERS_BANK_SIZE*BUS_SIZE  register bank debug bus; reg i at bits [(i+1)*BUS_SIZE-1 : i*BUS_SIZE]
o_pipeline_enable  out  1  stage enable for all pipeline registers
o_tx_data  out  8  outgoing byte
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  sink accepts byte when o_tx_valid && i_tx_ready
o_cycle_count  out  CYCLE_COUNTER_SIZE  number of cycles with o_pipeline_enable high since reset
o_busy  out  1  state != IDLE

Behaviour:
- Reset, synchronous: state IDLE; o_pipeline_enable 0, o_tx_valid 0, o_tx_data 0x00, o_cycle_count 0, byte index 0, snapshot 0. o_cmd_ready 1. Reset mid-operation aborts at the next edge without completing any pending byte.
- All outputs except o_cmd_ready and o_busy are registered. o_cmd_ready and o_busy decode from state.
- States: IDLE, RUN, STEP, SNAP, SEND, ERR.
- IDLE: o_cmd_ready 1. Accepted command transitions:
  - 'C' goes to RUN.
  - 'S' goes to STEP.
  - 'D' goes to SNAP.
  - 'H' stays in IDLE.
  - Any other byte goes to ERR.
  - i_halt_detected is ignored.
- RUN: o_pipeline_enable is 1 in every RUN cycle; the first high cycle is the cycle after acceptance. o_cmd_ready is 1.
  - i_halt_detected high in a RUN cycle: that cycle is the last enabled cycle, then go to SNAP.
  - 'H' accepted: that cycle is the last enabled cycle, then go to IDLE with no dump.
  - Halt and 'H' in the same cycle: halt wins and the block goes to SNAP.
  - Other commands are accepted and discarded.
- STEP: o_pipeline_enable high for exactly one cycle, then SNAP regardless of i_halt_detected. o_cmd_ready 0.
- SNAP: lasts one cycle. Latch i_registers_bank into the snapshot, clear the byte index, go to SEND. o_cmd_ready 0.
- SEND: o_cmd_ready 0.
  - Byte index k runs from 0 to N-1, with N = REGISTERS_BANK_SIZE*BUS_SIZE/8 (128 at defaults).
  - Register 0 is sent first. Within a register, the most significant byte is sent first.
  - o_tx_valid asserts the first SEND cycle.
  - o_tx_data and o_tx_valid are held stable while i_tx_ready is 0.
  - On a handshake, the next byte is presented in the following cycle, so back-to-back transfers are possible.
  - After the handshake of byte N-1: o_tx_valid goes to 0 and the state goes to IDLE.
- ERR: send a single byte 0xEE with the same handshake rules, then go to IDLE.
- o_cycle_count increments on every cycle with o_pipeline_enable 1 and saturates at all-ones. It is never cleared except by reset.
- The snapshot is immune to bus changes during SEND. The pipeline is stalled then, since o_pipeline_enable is 0 in every state except RUN and STEP.

Test Plan:
- Reset held 3 cycles, then released -> o_pipeline_enable 0, o_tx_valid 0, o_cycle_count 0, o_cmd_ready 1, o_busy 0.
- 'S' with reg1=0x11223344 and i_tx_ready tied 1 -> o_pipeline_enable high exactly 1 cycle, o_cycle_count=1; 128 consecutive bytes follow; bytes 4..7 = 0x11,0x22,0x33,0x44; o_busy returns 0.
- 'C' with i_halt_detected asserted on the 10th enabled cycle -> o_cycle_count=10, o_pipeline_enable low the next cycle, full 128-byte dump follows.
- Dump with i_tx_ready alternating 1/0 and i_registers_bank changed mid-dump -> exactly 128 handshakes, no byte duplicated or dropped, o_tx_data stable while stalled, values match the SNAP-time bus.
- Command 0x58 -> single byte 0xEE, then IDLE. 'C' then 'H' after 5 cycles -> o_cycle_count=5, no tx activity, IDLE.
- Reset asserted after byte 50 handshake -> next cycle o_tx_valid 0, IDLE. A following 'D' restarts from byte 0.
